// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit signed immediate into the RV32I immediate
// fields of a base instruction word, selected by the 2-bit immediate-type
// code. Streaming valid/ready on both sides with a registered output and a
// one-word skid register, so a word can be accepted every cycle.
//
// Build option: define IMM_ENCODER_RANGE_CHECK_EN to flag immediates that do
// not fit (or are misaligned for) the selected type on o_err. Without it,
// o_err is tied low and the immediate is silently truncated.
//
// FSM states (occupancy of output + skid registers):
//   state   | meaning
//   S_EMPTY | nothing held; o_valid=0, o_ready=1
//   S_ONE   | one word in output register; o_valid=1, o_ready=1
//   S_FULL  | output and skid both hold a word; o_valid=1, o_ready=0

module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_base,
  input  logic [1:0]       i_immsrc,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_instr,
  output logic             o_err,
  output logic [CNT_W-1:0] o_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_valid;
  logic             r_ready;
  logic [31:0]      r_instr;
  logic             r_err;
  logic [31:0]      r_skid_instr;
  logic             r_skid_err;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      w_enc_instr;
  logic             w_enc_err;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_in_xfer  = i_valid && r_ready;
  assign w_out_xfer = r_valid && i_ready;

  // Pack the immediate into the type's field positions; other bits come from the base word.
  always_comb begin
    w_enc_instr = i_base;
    case (i_immsrc)
      2'b00:   w_enc_instr = {i_imm[11:0], i_base[19:0]};
      2'b01:   w_enc_instr = {i_imm[11:5], i_base[24:12], i_imm[4:0], i_base[6:0]};
      2'b10:   w_enc_instr = {i_imm[12], i_imm[10:5], i_base[24:12],
                              i_imm[4:1], i_imm[11], i_base[6:0]};
      default: w_enc_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                              i_base[11:0]};
    endcase
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  logic w_fit_11;
  logic w_fit_12;
  logic w_fit_20;

  assign w_fit_11 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_fit_12 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_fit_20 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  // Flag immediates whose sign-extended value would not round-trip through the fields.
  always_comb begin
    w_enc_err = 1'b0;
    case (i_immsrc)
      2'b00:   w_enc_err = ~w_fit_11;
      2'b01:   w_enc_err = ~w_fit_11;
      2'b10:   w_enc_err = ~w_fit_12 | i_imm[0];
      default: w_enc_err = ~w_fit_20 | i_imm[0];
    endcase
  end
`else
  // Upper immediate bits only matter to the range check.
  logic w_unused_imm;
  assign w_unused_imm = ^i_imm[31:21];
  assign w_enc_err    = 1'b0;
`endif

  // Occupancy FSM: moves words between input, skid and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_EMPTY;
      r_valid      <= 1'b0;
      r_ready      <= 1'b1;
      r_instr      <= 32'd0;
      r_err        <= 1'b0;
      r_skid_instr <= 32'd0;
      r_skid_err   <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_in_xfer) begin
        r_count <= r_count + CNT_W'(1);
      end
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_instr <= w_enc_instr;
            r_err   <= w_enc_err;
            r_valid <= 1'b1;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_instr <= w_enc_instr;
            r_err   <= w_enc_err;
          end else if (w_in_xfer) begin
            r_skid_instr <= w_enc_instr;
            r_skid_err   <= w_enc_err;
            r_ready      <= 1'b0;
            r_state      <= S_FULL;
          end else if (w_out_xfer) begin
            r_valid <= 1'b0;
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            r_instr <= r_skid_instr;
            r_err   <= r_skid_err;
            r_ready <= 1'b1;
            r_state <= S_ONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_err   = r_err;
  assign o_count = r_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder: packing per type, range flag,
// backpressure through the skid register, full-rate streaming and reset.
module tb_imm_encoder;

  localparam int CNT_W = 16;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_base;
  logic [1:0]       i_immsrc;
  logic [31:0]      i_imm;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_instr;
  logic             o_err;
  logic [CNT_W-1:0] o_count;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_base   (i_base),
    .i_immsrc (i_immsrc),
    .i_imm    (i_imm),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_instr  (o_instr),
    .o_err    (o_err),
    .o_count  (o_count)
  );

  always #5 i_clk = ~i_clk;

  // Sign-extender as used in decode; the inverse of the DUT's packing.
  function automatic logic [31:0] sext(input logic [31:0] x, input logic [1:0] src);
    case (src)
      2'b00:   sext = {{20{x[31]}}, x[31:20]};
      2'b01:   sext = {{20{x[31]}}, x[31:25], x[11:7]};
      2'b10:   sext = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      default: sext = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] keep_mask(input logic [1:0] src);
    case (src)
      2'b00:   keep_mask = 32'h000F_FFFF;
      2'b01:   keep_mask = 32'h01FF_F07F;
      2'b10:   keep_mask = 32'h01FF_F07F;
      default: keep_mask = 32'h0000_0FFF;
    endcase
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    exp_count = 0;
  endtask

  // Present one word for a single edge (caller guarantees o_ready is high).
  task automatic drive_word(input logic [31:0] base, input logic [1:0] src, input logic [31:0] imm);
    i_base   = base;
    i_immsrc = src;
    i_imm    = imm;
    i_valid  = 1'b1;
    tick();
    i_valid  = 1'b0;
    exp_count++;
  endtask

  task automatic test_reset();
    i_ready = 1'b0;
    i_base = 32'd0; i_immsrc = 2'b00; i_imm = 32'd0;
    do_reset();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (o_instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", o_instr); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", o_err); end
    checks++; if (o_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
  endtask

  task automatic test_i_pack();
    i_ready = 1'b1;
    drive_word(32'h0000_0013, 2'b00, 32'hFFFF_FFFF);
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL i_valid got=%b exp=1", o_valid); end
    checks++; if (o_instr !== 32'hFFF0_0013) begin failures++; $display("FAIL i_instr got=%h exp=fff00013", o_instr); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL i_err got=%b exp=0", o_err); end
    checks++; if (o_count !== 16'd1) begin failures++; $display("FAIL i_count got=%0d exp=1", o_count); end
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL i_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_s_b_pack();
    i_ready = 1'b1;
    drive_word(32'h0000_2023, 2'b01, 32'd8);
    checks++; if (o_instr !== 32'h0000_2423) begin failures++; $display("FAIL s_instr got=%h exp=00002423", o_instr); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL s_err got=%b exp=0", o_err); end
    tick();
    drive_word(32'h0000_0063, 2'b10, 32'hFFFF_FFFC);
    checks++; if (o_instr !== 32'hFE00_0EE3) begin failures++; $display("FAIL b_instr got=%h exp=fe000ee3", o_instr); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL b_err got=%b exp=0", o_err); end
    tick();
  endtask

  task automatic test_j_range();
    i_ready = 1'b1;
    drive_word(32'h0000_00EF, 2'b11, 32'h0000_0800);
    checks++; if (o_instr !== 32'h0010_00EF) begin failures++; $display("FAIL j_instr got=%h exp=001000ef", o_instr); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL j_err got=%b exp=0", o_err); end
    tick();
    drive_word(32'h0000_00EF, 2'b11, 32'h0010_0000);
    checks++; if (o_instr !== 32'h8000_00EF) begin failures++; $display("FAIL j_range_instr got=%h exp=800000ef", o_instr); end
    checks++; if (o_err !== ERR_ON) begin failures++; $display("FAIL j_range_err got=%b exp=%b", o_err, ERR_ON); end
    tick();
    drive_word(32'h0000_0063, 2'b10, 32'd3);
    checks++; if (o_instr !== 32'h0000_0163) begin failures++; $display("FAIL b_align_instr got=%h exp=00000163", o_instr); end
    checks++; if (o_err !== ERR_ON) begin failures++; $display("FAIL b_align_err got=%b exp=%b", o_err, ERR_ON); end
    tick();
    drive_word(32'h0000_0013, 2'b00, 32'h0000_0800);
    checks++; if (o_err !== ERR_ON) begin failures++; $display("FAIL i_range_err got=%b exp=%b", o_err, ERR_ON); end
    tick();
    drive_word(32'h0000_0013, 2'b00, 32'h0000_07FF);
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL i_edge_err got=%b exp=0", o_err); end
    tick();
    checks++; if (o_count !== 16'(exp_count)) begin failures++; $display("FAIL j_count got=%0d exp=%0d", o_count, exp_count); end
  endtask

  task automatic test_backpressure();
    i_ready  = 1'b0;
    i_base   = 32'h0000_0013;
    i_immsrc = 2'b00;
    i_imm    = 32'd1;
    i_valid  = 1'b1;
    tick(); exp_count++;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", o_ready); end
    checks++; if (o_instr !== 32'h0010_0013) begin failures++; $display("FAIL bp_out1 got=%h exp=00100013", o_instr); end
    i_imm = 32'd2;
    tick(); exp_count++;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b exp=0", o_ready); end
    checks++; if (o_instr !== 32'h0010_0013) begin failures++; $display("FAIL bp_hold1 got=%h exp=00100013", o_instr); end
    i_imm = 32'd3;
    tick();
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready3 got=%b exp=0", o_ready); end
    checks++; if (o_instr !== 32'h0010_0013 || o_valid !== 1'b1) begin failures++; $display("FAIL bp_hold2 got=%h/%b exp=00100013/1", o_instr, o_valid); end
    checks++; if (o_count !== 16'(exp_count)) begin failures++; $display("FAIL bp_count_held got=%0d exp=%0d", o_count, exp_count); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_instr !== 32'h0020_0013 || o_valid !== 1'b1) begin failures++; $display("FAIL bp_out2 got=%h/%b exp=00200013/1", o_instr, o_valid); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_ready4 got=%b exp=1", o_ready); end
    tick(); exp_count++;
    i_valid = 1'b0;
    checks++; if (o_instr !== 32'h0030_0013 || o_valid !== 1'b1) begin failures++; $display("FAIL bp_out3 got=%h/%b exp=00300013/1", o_instr, o_valid); end
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", o_valid); end
    checks++; if (o_count !== 16'(exp_count)) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", o_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    int          ready_low;
    int          outs;
    int          v;
    logic [31:0] imm_w;
    logic [31:0] base_w;
    logic [1:0]  src_w;
    logic [31:0] m;
    do_reset();
    ready_low = 0;
    outs      = 0;
    i_ready   = 1'b1;
    for (int n = 0; n < 100; n++) begin
      src_w  = 2'(n % 4);
      base_w = $urandom;
      case (src_w)
        2'b00, 2'b01: v = int'($urandom_range(0, 4095)) - 2048;
        2'b10:        v = (int'($urandom_range(0, 8191)) - 4096) & -2;
        default:      v = (int'($urandom_range(0, 2097151)) - 1048576) & -2;
      endcase
      imm_w    = v;
      if (o_ready !== 1'b1) ready_low++;
      i_base   = base_w;
      i_immsrc = src_w;
      i_imm    = imm_w;
      i_valid  = 1'b1;
      tick();
      if (o_valid === 1'b1) outs++;
      m = keep_mask(src_w);
      checks++;
      if (sext(o_instr, src_w) !== imm_w || (o_instr & m) !== (base_w & m) || o_err !== 1'b0) begin
        failures++;
        $display("FAIL rt_%0d got=%h err=%b exp_imm=%h base=%h src=%0d", n, o_instr, o_err, imm_w, base_w, src_w);
      end
    end
    i_valid = 1'b0;
    tick();
    checks++; if (ready_low !== 0) begin failures++; $display("FAIL tp_ready_low got=%0d exp=0", ready_low); end
    checks++; if (outs !== 100) begin failures++; $display("FAIL tp_outputs got=%0d exp=100", outs); end
    checks++; if (o_count !== 16'd100) begin failures++; $display("FAIL tp_count got=%0d exp=100", o_count); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL tp_drain got=%b exp=0", o_valid); end
  endtask

  task automatic test_reset_mid();
    int stale;
    i_ready  = 1'b0;
    i_base   = 32'h0000_0013;
    i_immsrc = 2'b00;
    i_imm    = 32'd5;
    i_valid  = 1'b1;
    tick();
    i_imm = 32'd6;
    tick();
    i_valid = 1'b0;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rm_full got=%b exp=0", o_ready); end
    i_ready = 1'b1;
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", o_ready); end
    checks++; if (o_count !== 16'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", o_count); end
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin failures++; $display("FAIL rm_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_base   = 32'd0;
    i_immsrc = 2'b00;
    i_imm    = 32'd0;
    test_reset();
    test_i_pack();
    test_s_b_pack();
    test_j_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extender: packs a 32-bit signed immediate into the RV32I immediate bit-fields of a base instruction word.
- Selected by the same 2-bit immediate-type code the extender uses.
- Used by the instruction-patch / boot-loader path that builds instructions in hardware.
- Streaming block: valid/ready on both sides, registered output, 2-entry skid for full throughput, per-transfer range flag, transfer counter.

Parameters:
- CNT_W, 16, width of the accepted-transfer counter o_count (wraps).

Ports:
- i_clk     input   1   clock; all state updates on rising edge
- i_rst_n   input   1   synchronous active-low reset
- i_valid   input   1   input word valid
- o_ready   output  1   block can accept input this cycle
- i_base    input   32  base instruction; opcode/rd/rs1/rs2/funct bits kept as-is
- i_immsrc  input   2   00 I-type, 01 S-type, 10 B-type, 11 J-type
- i_imm     input   32  signed immediate, byte offset for B/J
- o_valid   output  1   output word valid
- i_ready   input   1   downstream accepts output
- o_instr   output  32  encoded instruction
- o_err     output  1   immediate out of range or misaligned for o_instr's type
- o_count   output  CNT_W  number of input transfers accepted since reset

Behaviour:
- Transfers:
  - Input transfer when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - o_valid, once high, holds with o_instr/o_err stable until the output transfer.
- Field packing (bits not listed are copied from i_base):
  - I: [31:20] = imm[11:0].
  - S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
  - B: [31] = imm[12]; [30:25] = imm[10:5]; [11:8] = imm[4:1]; [7] = imm[11].
  - J: [31] = imm[20]; [30:21] = imm[10:1]; [20] = imm[11]; [19:12] = imm[19:12].
- Range rules:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0] = 0.
  - J: imm[31:20] all equal and imm[0] = 0.
  - Violation sets o_err for that word only.
  - On violation, o_instr still carries the truncated fields as packed above.
- Encoding is combinational on the input and captured into the output or skid register. Latency is 1 cycle from input transfer to o_valid.
- State machine, with occupancy 0..2:
  - EMPTY: o_valid = 0, o_ready = 1. Input transfer -> ONE (word in output register).
  - ONE: o_valid = 1, o_ready = 1.
    - Input and output transfer together -> ONE, new word replaces output.
    - Input only -> FULL, new word goes to skid.
    - Output only -> EMPTY.
    - Neither -> hold.
  - FULL: o_valid = 1, o_ready = 0.
    - Output transfer -> ONE, skid word moves to output the same edge.
    - Otherwise hold.
- o_ready is a registered-state decode only (not combinational on i_ready): o_ready = !FULL.
- o_count increments by 1 on every input transfer and wraps modulo 2^CNT_W.
- Reset (i_rst_n = 0 at the edge):
  - State -> EMPTY.
  - o_valid = 0, o_ready = 1 from the first cycle after reset.
  - o_instr = 0, o_err = 0, o_count = 0.
  - Skid contents discarded.
  - Reset mid-stream drops both held words; no output transfer occurs on the reset edge.
- Invalid immsrc does not exist (2-bit, fully decoded). No X propagation is permitted on outputs.
- Round-trip property: for in-range imm, sign-extending o_instr with the same immsrc returns i_imm exactly.

Optional Feature:
- Macro IMM_ENCODER_RANGE_CHECK_EN.
- Defined: range/alignment checking as above; o_err driven per word.
- Undefined: no check logic; o_err tied 0. Fields are still truncated per the packing rules; imm[0] is silently dropped for B/J.

Test Plan:
- I pack: base 0x00000013, immsrc 00, imm 0xFFFFFFFF, i_ready = 1 -> one cycle later o_instr 0xFFF00013, o_err 0, o_count 1.
- S/B pack:
  - base 0x00002023, immsrc 01, imm 8 -> 0x00002423.
  - base 0x00000063, immsrc 10, imm -4 -> 0xFE000EE3.
- J pack and range:
  - base 0x000000EF, immsrc 11, imm 0x800 -> 0x001000EF, o_err 0.
  - imm 0x100000 -> o_err 1 (with IMM_ENCODER_RANGE_CHECK_EN); o_err 0 without.
  - B with imm 3 -> o_err 1.
- Backpressure:
  - Stream of 3 words with i_ready = 0: o_ready drops after the 2nd accept, 3rd held upstream.
  - Raise i_ready: words emerge in order, one per cycle; no loss or duplication.
- Full throughput: i_valid = i_ready = 1 for 100 cycles of random in-range imm -> 100 outputs back-to-back, o_ready never 0, every word passes the round-trip check, o_count 100.
- Reset mid-operation: state FULL, assert i_rst_n = 0 for one edge -> next cycle o_valid 0, o_ready 1, o_count 0; no stale word appears afterwards.
